// File: rtl/hsv_to_rgb.sv
`default_nettype none
// ============================================================================
// Module   : hsv_to_rgb
// Brief    : Four-stage HSV-to-RGB pixel converter with per-pixel bypass and
//            a delay-matched sideband channel.
// Revision : 1.0 - initial release
// ============================================================================
module hsv_to_rgb (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        bypass,
    input  logic [23:0] pixel_in,
    input  logic [23:0] pass_in,
    output logic [23:0] pixel_out,
    output logic [23:0] pass_thru,
    output logic        out_valid
);

    localparam logic [8:0]  c_H_WRAP = 9'd360;
    localparam logic [5:0]  c_SIXTY  = 6'd60;
    localparam logic [25:0] c_RECIP  = 26'd1093;

    // ---------------- stage 1: hue fold, sector and offset ----------------
    logic [8:0] w_h;
    logic [8:0] w_hw;
    logic [2:0] w_sector;
    logic [8:0] w_base;
    logic [5:0] w_f;

    assign w_h  = pixel_in[23:15];
    assign w_hw = (w_h >= c_H_WRAP) ? (w_h - c_H_WRAP) : w_h;

    always_comb begin
        w_sector = 3'd0;
        w_base   = 9'd0;
        if (w_hw >= 9'd300) begin
            w_sector = 3'd5;
            w_base   = 9'd300;
        end else if (w_hw >= 9'd240) begin
            w_sector = 3'd4;
            w_base   = 9'd240;
        end else if (w_hw >= 9'd180) begin
            w_sector = 3'd3;
            w_base   = 9'd180;
        end else if (w_hw >= 9'd120) begin
            w_sector = 3'd2;
            w_base   = 9'd120;
        end else if (w_hw >= 9'd60) begin
            w_sector = 3'd1;
            w_base   = 9'd60;
        end
    end

    assign w_f = 6'(w_hw - w_base);

    logic        r_s1_valid;
    logic        r_s1_bypass;
    logic [23:0] r_s1_pixel;
    logic [23:0] r_s1_pass;
    logic [2:0]  r_s1_sector;
    logic [5:0]  r_s1_f;
    logic [6:0]  r_s1_s;
    logic [7:0]  r_s1_v;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_pixel  <= 24'd0;
            r_s1_pass   <= 24'd0;
            r_s1_sector <= 3'd0;
            r_s1_f      <= 6'd0;
            r_s1_s      <= 7'd0;
            r_s1_v      <= 8'd0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_bypass <= bypass;
                r_s1_pixel  <= pixel_in;
                r_s1_pass   <= pass_in;
                r_s1_sector <= w_sector;
                r_s1_f      <= w_f;
                r_s1_s      <= pixel_in[14:8];
                r_s1_v      <= pixel_in[7:0];
            end
        end
    end

    // ---------------- stage 2: chroma and offset --------------------------
    logic [14:0] w_vs;
    logic [7:0]  w_c;

    assign w_vs = {7'd0, r_s1_v} * {8'd0, r_s1_s};
    assign w_c  = 8'(w_vs >> 7);

    logic        r_s2_valid;
    logic        r_s2_bypass;
    logic [23:0] r_s2_pixel;
    logic [23:0] r_s2_pass;
    logic [2:0]  r_s2_sector;
    logic [5:0]  r_s2_f;
    logic [7:0]  r_s2_c;
    logic [7:0]  r_s2_m;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_bypass <= 1'b0;
            r_s2_pixel  <= 24'd0;
            r_s2_pass   <= 24'd0;
            r_s2_sector <= 3'd0;
            r_s2_f      <= 6'd0;
            r_s2_c      <= 8'd0;
            r_s2_m      <= 8'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_bypass <= r_s1_bypass;
                r_s2_pixel  <= r_s1_pixel;
                r_s2_pass   <= r_s1_pass;
                r_s2_sector <= r_s1_sector;
                r_s2_f      <= r_s1_f;
                r_s2_c      <= w_c;
                r_s2_m      <= r_s1_v - w_c;
            end
        end
    end

    // ---------------- stage 3: secondary component X ----------------------
    // 1093/65536 approximates 1/60, so X ~= C*t/60 without a divider.
    logic [5:0]  w_t;
    logic [25:0] w_prod;
    logic [7:0]  w_x_raw;
    logic [7:0]  w_x;

    assign w_t     = r_s2_sector[0] ? (c_SIXTY - r_s2_f) : r_s2_f;
    assign w_prod  = {18'd0, r_s2_c} * {20'd0, w_t} * c_RECIP;
    assign w_x_raw = 8'(w_prod >> 16);
    assign w_x     = (w_x_raw > r_s2_c) ? r_s2_c : w_x_raw;

    logic        r_s3_valid;
    logic        r_s3_bypass;
    logic [23:0] r_s3_pixel;
    logic [23:0] r_s3_pass;
    logic [2:0]  r_s3_sector;
    logic [7:0]  r_s3_c;
    logic [7:0]  r_s3_m;
    logic [7:0]  r_s3_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s3_valid  <= 1'b0;
            r_s3_bypass <= 1'b0;
            r_s3_pixel  <= 24'd0;
            r_s3_pass   <= 24'd0;
            r_s3_sector <= 3'd0;
            r_s3_c      <= 8'd0;
            r_s3_m      <= 8'd0;
            r_s3_x      <= 8'd0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_bypass <= r_s2_bypass;
                r_s3_pixel  <= r_s2_pixel;
                r_s3_pass   <= r_s2_pass;
                r_s3_sector <= r_s2_sector;
                r_s3_c      <= r_s2_c;
                r_s3_m      <= r_s2_m;
                r_s3_x      <= w_x;
            end
        end
    end

    // ---------------- stage 4: sector map, add m, saturate ----------------
    logic [7:0] w_rp;
    logic [7:0] w_gp;
    logic [7:0] w_bp;

    always_comb begin
        w_rp = 8'd0;
        w_gp = 8'd0;
        w_bp = 8'd0;
        case (r_s3_sector)
            3'd0: begin w_rp = r_s3_c; w_gp = r_s3_x; end
            3'd1: begin w_rp = r_s3_x; w_gp = r_s3_c; end
            3'd2: begin w_gp = r_s3_c; w_bp = r_s3_x; end
            3'd3: begin w_gp = r_s3_x; w_bp = r_s3_c; end
            3'd4: begin w_rp = r_s3_x; w_bp = r_s3_c; end
            3'd5: begin w_rp = r_s3_c; w_bp = r_s3_x; end
            default: ;
        endcase
    end

    logic [8:0] w_r_sum;
    logic [8:0] w_g_sum;
    logic [8:0] w_b_sum;
    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

    assign w_r_sum = {1'b0, w_rp} + {1'b0, r_s3_m};
    assign w_g_sum = {1'b0, w_gp} + {1'b0, r_s3_m};
    assign w_b_sum = {1'b0, w_bp} + {1'b0, r_s3_m};
    assign w_r     = w_r_sum[8] ? 8'hFF : w_r_sum[7:0];
    assign w_g     = w_g_sum[8] ? 8'hFF : w_g_sum[7:0];
    assign w_b     = w_b_sum[8] ? 8'hFF : w_b_sum[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            pixel_out <= 24'd0;
            pass_thru <= 24'd0;
        end else begin
            out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                pixel_out <= r_s3_bypass ? r_s3_pixel : {w_r, w_g, w_b};
                pass_thru <= r_s3_pass;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsv_to_rgb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsv_to_rgb
// Brief    : Scoreboard bench for hsv_to_rgb (latency, data, bypass, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsv_to_rgb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        bypass = 1'b0;
    logic [23:0] pixel_in = 24'd0;
    logic [23:0] pass_in = 24'd0;
    logic [23:0] pixel_out;
    logic [23:0] pass_thru;
    logic        out_valid;

    hsv_to_rgb dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .bypass    (bypass),
        .pixel_in  (pixel_in),
        .pass_in   (pass_in),
        .pixel_out (pixel_out),
        .pass_thru (pass_thru),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] pix;
        logic [23:0] pass;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [23:0] last_pix  = 24'd0;
    logic [23:0] last_pass = 24'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mk(input int h, input int s, input int v);
        logic [8:0] hh;
        logic [6:0] ss;
        logic [7:0] vv;
        hh = 9'(h);
        ss = 7'(s);
        vv = 8'(v);
        return {hh, ss, vv};
    endfunction

    function automatic int sat(input int a);
        return (a > 255) ? 255 : a;
    endfunction

    function automatic logic [23:0] model(input logic [23:0] p);
        int h, s, v, hw, sec, f, c, m, t, x, r, g, b;
        h  = int'(p[23:15]);
        s  = int'(p[14:8]);
        v  = int'(p[7:0]);
        hw = (h >= 360) ? h - 360 : h;
        sec = hw / 60;
        f  = hw % 60;
        c  = (v * s) / 128;
        m  = v - c;
        t  = (sec % 2 == 1) ? 60 - f : f;
        x  = (c * t * 1093) / 65536;
        if (x > c) x = c;
        r = 0; g = 0; b = 0;
        case (sec)
            0: begin r = c; g = x; end
            1: begin r = x; g = c; end
            2: begin g = c; b = x; end
            3: begin g = x; b = c; end
            4: begin r = x; b = c; end
            default: begin r = c; b = x; end
        endcase
        return {8'(sat(r + m)), 8'(sat(g + m)), 8'(sat(b + m))};
    endfunction

    // Runs at each falling edge: checks valid timing, data, and hold behaviour.
    task automatic monitor();
        logic exp_v;
        exp_t e;
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
        if (exp_v) begin
            e = sb.pop_front();
            chk("pixel_out", {8'd0, pixel_out}, {8'd0, e.pix});
            chk("pass_thru", {8'd0, pass_thru}, {8'd0, e.pass});
            last_pix  = e.pix;
            last_pass = e.pass;
        end else if (!out_valid) begin
            chk("hold_pixel", {8'd0, pixel_out}, {8'd0, last_pix});
            chk("hold_pass",  {8'd0, pass_thru}, {8'd0, last_pass});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic send(input logic [23:0] pix, input logic byp,
                        input logic [23:0] pass, input logic [23:0] exp_pix);
        exp_t e;
        in_valid = 1'b1;
        bypass   = byp;
        pixel_in = pix;
        pass_in  = pass;
        e.pix  = exp_pix;
        e.pass = pass;
        e.due  = cyc + 4;
        sb.push_back(e);
        tick();
    endtask

    task automatic send_conv(input logic [23:0] pix, input logic [23:0] pass);
        send(pix, 1'b0, pass, model(pix));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        bypass   = 1'b0;
        pixel_in = 24'h5A5A5A;
        pass_in  = 24'hA5A5A5;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [23:0] rp;
        logic        rb;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pixel_out", {8'd0, pixel_out}, 32'd0);
        chk("rst_pass_thru", {8'd0, pass_thru}, 32'd0);
        rst = 1'b1;

        // Directed reference vectors with hand-computed results
        send(24'h007FFF, 1'b0, 24'hABCDEF, 24'hFF0202);
        idle(5);
        send(mk(0,   0, 200), 1'b0, 24'h000001, 24'hC8C8C8);
        send(mk(200, 0, 200), 1'b0, 24'h000002, 24'hC8C8C8);
        send(mk(511, 0, 200), 1'b0, 24'h000003, 24'hC8C8C8);
        send(mk(120, 127, 255), 1'b0, 24'h000004, 24'h02FF02);
        send(mk(90,  127, 255), 1'b0, 24'h000005, 24'h80FF02);
        send(mk(400, 127, 255), 1'b0, 24'h000006, 24'hFFAA02);
        idle(2);
        send(24'h123456, 1'b1, 24'h000007, 24'h123456);
        idle(6);

        // Interleaved bypass and convert, plus sector boundaries
        send(mk(59, 100, 180), 1'b1, 24'h000010, mk(59, 100, 180));
        send_conv(mk(60, 100, 180), 24'h000011);
        send(mk(300, 90, 77), 1'b1, 24'h000012, mk(300, 90, 77));
        send_conv(mk(359, 127, 255), 24'h000013);
        send_conv(mk(360, 127, 255), 24'h000014);
        send_conv(mk(239, 64, 128), 24'h000015);
        send_conv(mk(300, 127, 1), 24'h000016);
        idle(6);

        // 16 back-to-back random pixels with incrementing sideband
        for (int i = 0; i < 16; i++) begin
            rp = 24'($urandom);
            rb = 1'($urandom_range(0, 3) == 0);
            send(rp, rb, 24'h100 + 24'(i), rb ? rp : model(rp));
        end
        idle(6);

        // Reset with three pixels in flight
        send_conv(mk(30, 127, 255), 24'h0000A1);
        send_conv(mk(150, 127, 255), 24'h0000A2);
        send_conv(mk(270, 127, 255), 24'h0000A3);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_pixel_out", {8'd0, pixel_out}, 32'd0);
        chk("async_pass_thru", {8'd0, pass_thru}, 32'd0);
        sb.delete();
        last_pix  = 24'd0;
        last_pass = 24'd0;
        idle(2);
        rst = 1'b1;
        idle(6);
        send_conv(mk(210, 127, 200), 24'h0000B1);
        idle(6);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
